iob_axi_mem_bridge: RTL



---
 rtl/iob_axi_mem_bridge.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/iob_axi_mem_bridge.sv
// Arbitrates N_MASTERS IOb native masters onto one AXI4 master port, one single-beat transaction at a time.
// Define IOB_AXI_MEM_BRIDGE_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module iob_axi_mem_bridge #(
  parameter int N_MASTERS  = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_ADDR_W = 24,
  parameter int AXI_ID_W   = 4
) (
  input  logic                           clk_i,
  input  logic                           arst_n_i,
  input  logic                           cke_i,
  input  logic [N_MASTERS-1:0]           m_avalid_i,
  input  logic [N_MASTERS*ADDR_W-1:0]    m_addr_i,
  input  logic [N_MASTERS*DATA_W-1:0]    m_wdata_i,
  input  logic [N_MASTERS*DATA_W/8-1:0]  m_wstrb_i,
  output logic [N_MASTERS*DATA_W-1:0]    m_rdata_o,
  output logic [N_MASTERS-1:0]           m_rvalid_o,
  output logic [N_MASTERS-1:0]           m_ready_o,
  output logic                           err_o,
  output logic [AXI_ID_W-1:0]            axi_awid_o,
  output logic [MEM_ADDR_W-1:0]          axi_awaddr_o,
  output logic [7:0]                     axi_awlen_o,
  output logic [2:0]                     axi_awsize_o,
  output logic [1:0]                     axi_awburst_o,
  output logic                           axi_awlock_o,
  output logic [3:0]                     axi_awcache_o,
  output logic [2:0]                     axi_awprot_o,
  output logic [3:0]                     axi_awqos_o,
  output logic                           axi_awvalid_o,
  input  logic                           axi_awready_i,
  output logic [DATA_W-1:0]              axi_wdata_o,
  output logic [DATA_W/8-1:0]            axi_wstrb_o,
  output logic                           axi_wlast_o,
  output logic                           axi_wvalid_o,
  input  logic                           axi_wready_i,
  input  logic [AXI_ID_W-1:0]            axi_bid_i,
  input  logic [1:0]                     axi_bresp_i,
  input  logic                           axi_bvalid_i,
  output logic                           axi_bready_o,
  output logic [AXI_ID_W-1:0]            axi_arid_o,
  output logic [MEM_ADDR_W-1:0]          axi_araddr_o,
  output logic [7:0]                     axi_arlen_o,
  output logic [2:0]                     axi_arsize_o,
  output logic [1:0]                     axi_arburst_o,
  output logic                           axi_arlock_o,
  output logic [3:0]                     axi_arcache_o,
  output logic [2:0]                     axi_arprot_o,
  output logic [3:0]                     axi_arqos_o,
  output logic                           axi_arvalid_o,
  input  logic                           axi_arready_i,
  input  logic [AXI_ID_W-1:0]            axi_rid_i,
  input  logic [DATA_W-1:0]              axi_rdata_i,
  input  logic [1:0]                     axi_rresp_i,
  input  logic                           axi_rlast_i,
  input  logic                           axi_rvalid_i,
  output logic                           axi_rready_o
);

  localparam int IDX_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WADDR = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t                              state_q, state_d;
  logic [IDX_W-1:0]                    grant_q, grant_d;
  logic [MEM_ADDR_W-1:0]               addr_q, addr_d;
  logic [DATA_W-1:0]                   wdata_q, wdata_d;
  logic [STRB_W-1:0]                   wstrb_q, wstrb_d;
  logic                                awvalid_q, awvalid_d;
  logic                                wvalid_q, wvalid_d;
  logic                                bready_q, bready_d;
  logic                                arvalid_q, arvalid_d;
  logic                                rready_q, rready_d;
  logic [N_MASTERS-1:0]                m_ready_q, m_ready_d;
  logic [N_MASTERS-1:0]                m_rvalid_q, m_rvalid_d;
  logic [N_MASTERS-1:0][DATA_W-1:0]    m_rdata_q, m_rdata_d;
  logic                                err_q, err_d;

  logic                                req_any;
  logic [IDX_W-1:0]                    req_sel;

`ifdef IOB_AXI_MEM_BRIDGE_RR_EN
  logic [IDX_W-1:0]                    ptr_q, ptr_d;
  int unsigned                         rr_idx;

  // Search starts at the pointer and wraps; first requester found wins.
  always_comb begin
    req_any = 1'b0;
    req_sel = '0;
    rr_idx  = 0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      rr_idx = (32'(ptr_q) + i) % N_MASTERS;
      if (!req_any && m_avalid_i[rr_idx]) begin
        req_any = 1'b1;
        req_sel = IDX_W'(rr_idx);
      end
    end
  end
`else
  always_comb begin
    req_any = 1'b0;
    req_sel = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      if (!req_any && m_avalid_i[i]) begin
        req_any = 1'b1;
        req_sel = IDX_W'(i);
      end
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    m_ready_d  = '0;
    m_rvalid_d = '0;
    m_rdata_d  = m_rdata_q;
    err_d      = err_q;
`ifdef IOB_AXI_MEM_BRIDGE_RR_EN
    ptr_d      = ptr_q;
`endif

    case (state_q)
      IDLE: begin
        if (req_any) begin
          grant_d = req_sel;
          addr_d  = m_addr_i[req_sel*ADDR_W +: MEM_ADDR_W];
          wdata_d = m_wdata_i[req_sel*DATA_W +: DATA_W];
          wstrb_d = m_wstrb_i[req_sel*STRB_W +: STRB_W];
          if (|m_wstrb_i[req_sel*STRB_W +: STRB_W]) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WADDR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RADDR;
          end
        end
      end
      WADDR: begin
        // AW and W retire independently; advance once neither is still pending.
        if (awvalid_q && axi_awready_i) awvalid_d = 1'b0;
        if (wvalid_q && axi_wready_i)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WRESP;
        end
      end
      WRESP: begin
        if (axi_bvalid_i) begin
          bready_d           = 1'b0;
          err_d              = err_q | (|axi_bresp_i);
          m_ready_d[grant_q] = 1'b1;
          state_d            = DONE;
        end
      end
      RADDR: begin
        if (axi_arready_i) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RDATA;
        end
      end
      RDATA: begin
        if (axi_rvalid_i) begin
          rready_d            = 1'b0;
          err_d               = err_q | (|axi_rresp_i);
          m_rdata_d[grant_q]  = axi_rdata_i;
          m_rvalid_d[grant_q] = 1'b1;
          m_ready_d[grant_q]  = 1'b1;
          state_d             = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef IOB_AXI_MEM_BRIDGE_RR_EN
        ptr_d = (grant_q == IDX_W'(N_MASTERS - 1)) ? '0 : grant_q + 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      m_ready_q  <= '0;
      m_rvalid_q <= '0;
      m_rdata_q  <= '0;
      err_q      <= 1'b0;
`ifdef IOB_AXI_MEM_BRIDGE_RR_EN
      ptr_q      <= '0;
`endif
    end else if (cke_i) begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      m_ready_q  <= m_ready_d;
      m_rvalid_q <= m_rvalid_d;
      m_rdata_q  <= m_rdata_d;
      err_q      <= err_d;
`ifdef IOB_AXI_MEM_BRIDGE_RR_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  assign m_rdata_o     = m_rdata_q;
  assign m_rvalid_o    = m_rvalid_q;
  assign m_ready_o     = m_ready_q;
  assign err_o         = err_q;

  assign axi_awid_o    = AXI_ID_W'(grant_q);
  assign axi_awaddr_o  = addr_q;
  assign axi_awvalid_o = awvalid_q;
  assign axi_wdata_o   = wdata_q;
  assign axi_wstrb_o   = wstrb_q;
  assign axi_wlast_o   = 1'b1;
  assign axi_wvalid_o  = wvalid_q;
  assign axi_bready_o  = bready_q;
  assign axi_arid_o    = AXI_ID_W'(grant_q);
  assign axi_araddr_o  = addr_q;
  assign axi_arvalid_o = arvalid_q;
  assign axi_rready_o  = rready_q;

  assign axi_awlen_o   = '0;
  assign axi_arlen_o   = '0;
  assign axi_awsize_o  = 3'($clog2(STRB_W));
  assign axi_arsize_o  = 3'($clog2(STRB_W));
  assign axi_awburst_o = 2'b01;
  assign axi_arburst_o = 2'b01;
  assign axi_awlock_o  = 1'b0;
  assign axi_arlock_o  = 1'b0;
  assign axi_awcache_o = 4'b0011;
  assign axi_arcache_o = 4'b0011;
  assign axi_awprot_o  = '0;
  assign axi_arprot_o  = '0;
  assign axi_awqos_o   = '0;
  assign axi_arqos_o   = '0;

  // Response IDs are redundant with a single outstanding transaction; upper address bits are dropped.
  logic unused_inputs;
  assign unused_inputs = ^{axi_bid_i, axi_rid_i, axi_rlast_i, m_addr_i};

endmodule
